// File: rtl/pUart.sv
// Shared register map and bit positions for the UART receive controller.
package pUart;

    localparam logic [1:0] ADR_DATA   = 2'd0;
    localparam logic [1:0] ADR_STATUS = 2'd1;
    localparam logic [1:0] ADR_CTRL   = 2'd2;
    localparam logic [1:0] ADR_DIV    = 2'd3;

    localparam int unsigned ST_NOT_EMPTY = 0;
    localparam int unsigned ST_FULL      = 1;
    localparam int unsigned ST_OVERRUN   = 2;
    localparam int unsigned ST_FRAME_ERR = 3;

    localparam int unsigned CTRL_RX_EN   = 0;
    localparam int unsigned CTRL_IE_DATA = 1;
    localparam int unsigned CTRL_IE_ERR  = 2;
    localparam int unsigned CTRL_W       = 3;

    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_ACK  = 1'b1
    } bus_state_t;

endpackage

// File: rtl/mFifoSync.sv
// Single-clock FIFO with wrapping pointers; head data is visible combinationally.
module mFifoSync #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a push when the same cycle frees the head slot.
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Wishbone register front-end for a UART receiver: receive FIFO, sticky errors, interrupt, baud divisor.
module uart_rx_ctrl
    import pUart::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd104
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    input  logic        wb_we,
    input  logic [1:0]  wb_adr,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    output logic        wb_ack,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_ferr,
    output logic        rx_en,
    output logic [15:0] baud_div,
    output logic        irq
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    bus_state_t          state;
    bus_state_t          state_nxt;
    logic [CTRL_W-1:0]   ctrl;
    logic [15:0]         div;
    logic                overrun;
    logic                frame_err;
    logic                pop_pend;

    logic [7:0]          fifo_head;
    logic [CW-1:0]       fifo_count;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_pop_c;
    logic                push_req_c;
    logic                req_c;
    logic                commit_c;
    logic [15:0]         status_c;
    logic [15:0]         rd_word_c;

    always_ff @(posedge clk) begin
        if (rst) state <= BUS_IDLE;
        else     state <= state_nxt;
    end

    // Ack follows one cycle after a strobe, then forces an idle cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            BUS_IDLE: if (wb_cyc && wb_stb) state_nxt = BUS_ACK;
            BUS_ACK:  state_nxt = BUS_IDLE;
            default:  state_nxt = BUS_IDLE;
        endcase
    end

    assign wb_ack     = (state == BUS_ACK);
    assign req_c      = wb_cyc & wb_stb & (state == BUS_IDLE);
    assign commit_c   = wb_ack & wb_cyc & wb_stb & wb_we;
    assign fifo_pop_c = wb_ack & pop_pend;
    assign push_req_c = rx_valid & ctrl[CTRL_RX_EN];

    mFifoSync #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req_c),
        .pop   (fifo_pop_c),
        .wdata (rx_data),
        .rdata (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        status_c               = '0;
        status_c[ST_NOT_EMPTY] = ~fifo_empty;
        status_c[ST_FULL]      = fifo_full;
        status_c[ST_OVERRUN]   = overrun;
        status_c[ST_FRAME_ERR] = frame_err;
        status_c[15:8]         = 8'(fifo_count);
    end

    always_comb begin
        rd_word_c = '0;
        case (wb_adr)
            ADR_DATA:   rd_word_c = fifo_empty ? 16'h0000 : {8'h00, fifo_head};
            ADR_STATUS: rd_word_c = status_c;
            ADR_CTRL:   rd_word_c = 16'(ctrl);
            ADR_DIV:    rd_word_c = div;
            default:    rd_word_c = '0;
        endcase
    end

    // Read data is captured at the request edge; a DATA pop is committed at the end of the ack cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_dat_o <= '0;
            pop_pend <= 1'b0;
        end else begin
            pop_pend <= req_c & ~wb_we & (wb_adr == ADR_DATA) & ~fifo_empty;
            if (req_c && !wb_we) wb_dat_o <= rd_word_c;
        end
    end

    // Hardware sets of sticky flags take priority over a same-cycle W1C clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl      <= '0;
            div       <= DIV_RESET;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (commit_c && wb_adr == ADR_CTRL) ctrl <= wb_dat_i[CTRL_W-1:0];
            if (commit_c && wb_adr == ADR_DIV)  div  <= wb_dat_i;

            if (push_req_c && fifo_full && !fifo_pop_c)
                overrun <= 1'b1;
            else if (commit_c && wb_adr == ADR_STATUS && wb_dat_i[ST_OVERRUN])
                overrun <= 1'b0;

            if (push_req_c && rx_ferr)
                frame_err <= 1'b1;
            else if (commit_c && wb_adr == ADR_STATUS && wb_dat_i[ST_FRAME_ERR])
                frame_err <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) irq <= 1'b0;
        else     irq <= (ctrl[CTRL_IE_DATA] & ~fifo_empty)
                      | (ctrl[CTRL_IE_ERR] & (overrun | frame_err));
    end

    assign rx_en    = ctrl[CTRL_RX_EN];
    assign baud_div = div;

endmodule
